// File: rtl/bus_mem_slave.sv
// Byte-wide RAM target on the shared system bus: decoded window, fixed wait states, four-phase fc handshake.
// Optional MEM_WRITE_PROTECT_EN: offsets below WP_TOP complete writes without modifying the array.
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter int          WP_TOP      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        wr_bus,
  input  logic        rd_bus,
  output wire         fc_bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] off_q, off_d;
  logic                 op_wr_q, op_wr_d;
  logic [7:0]           wdat_q, wdat_d;
  logic [7:0]           rdata_q;
  logic                 mem_we, mem_re;
  logic                 sel, strobe_live, wp_ok;

  logic [7:0] mem [2**ADDR_BITS];

  assign sel         = (addr_bus[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign strobe_live = op_wr_q ? wr_bus : rd_bus;

`ifdef MEM_WRITE_PROTECT_EN
  assign wp_ok = ({{(32-ADDR_BITS){1'b0}}, off_q} >= 32'(WP_TOP));
`else
  assign wp_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    op_wr_d = op_wr_q;
    wdat_d  = wdat_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Both strobes high is a master protocol error and is not accepted.
        if (sel && (rd_bus ^ wr_bus)) begin
          off_d   = addr_bus[ADDR_BITS-1:0];
          op_wr_d = wr_bus;
          if (wr_bus) wdat_d = data_bus;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!strobe_live) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          mem_we  = op_wr_q && wp_ok && !rst;
          mem_re  = !op_wr_q && !rst;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (!strobe_live) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= '0;
      op_wr_q <= 1'b0;
      wdat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      op_wr_q <= op_wr_d;
      wdat_q  <= wdat_d;
    end
  end

  // Array is deliberately outside reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[off_q] <= wdat_q;
    if (mem_re) rdata_q <= mem[off_q];
  end

  assign fc_bus   = (state_q == ST_BUSY) ? 1'b0 :
                    (state_q == ST_ACK)  ? 1'b1 : 1'bz;
  assign data_bus = (state_q == ST_ACK && !op_wr_q) ? rdata_q : 8'bz;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench: u0 at base 0 with two wait states, u1 at base 0x400 with none; released lines read as pull values.
module tb_bus_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        rd_s = 1'b0;
  logic        wr_s = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  logic        tb_den = 1'b0;

  tri0       fc0, fc1;
  tri1 [7:0] data0, data1;

  int checks = 0;
  int failures = 0;

  assign data0 = tb_den ? tb_dat : 8'bz;
  assign data1 = tb_den ? tb_dat : 8'bz;

  always #5 clk = ~clk;

  bus_mem_slave #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(10), .WAIT_STATES(2), .WP_TOP(16)) u0 (
    .clk(clk), .rst(rst), .addr_bus(addr), .data_bus(data0),
    .wr_bus(wr_s), .rd_bus(rd_s), .fc_bus(fc0)
  );

  bus_mem_slave #(.BASE_ADDR(32'h0000_0400), .ADDR_BITS(10), .WAIT_STATES(0), .WP_TOP(0)) u1 (
    .clk(clk), .rst(rst), .addr_bus(addr), .data_bus(data1),
    .wr_bus(wr_s), .rd_bus(rd_s), .fc_bus(fc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = number of edges from the capture edge (1) until fc is seen high; -1 on timeout.
  task automatic xfer(input bit inst, input bit wr, input logic [31:0] a, input logic [7:0] wd,
                      output int lat, output logic [7:0] rdat);
    addr = a; wr_s = wr; rd_s = !wr; tb_dat = wd; tb_den = wr;
    lat = -1; rdat = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((inst ? fc1 : fc0) === 1'b1) begin
        lat = i;
        rdat = inst ? data1 : data0;
        break;
      end
    end
    rd_s = 1'b0; wr_s = 1'b0; tb_den = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (fc0 !== 1'b0) begin failures++; $display("FAIL reset_fc0 got=%b want=0", fc0); end
    checks++; if (data0 !== 8'hFF) begin failures++; $display("FAIL reset_data0 got=%h want=ff", data0); end
    checks++; if (fc1 !== 1'b0) begin failures++; $display("FAIL reset_fc1 got=%b want=0", fc1); end
    checks++; if (data1 !== 8'hFF) begin failures++; $display("FAIL reset_data1 got=%h want=ff", data1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int lat; logic [7:0] d;
    xfer(1'b0, 1'b1, 32'h5, 8'hA7, lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL write_lat got=%0d want=4", lat); end
    xfer(1'b0, 1'b0, 32'h5, 8'h00, lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL read_lat got=%0d want=4", lat); end
    checks++; if (d !== 8'hA7) begin failures++; $display("FAIL read_data got=%h want=a7", d); end
    checks++; if (fc0 !== 1'b0) begin failures++; $display("FAIL read_release_fc got=%b want=0", fc0); end
    checks++; if (data0 !== 8'hFF) begin failures++; $display("FAIL read_release_data got=%h want=ff", data0); end
  endtask

  task automatic test_write_readback();
    int lat; logic [7:0] d;
    xfer(1'b0, 1'b1, 32'h10, 8'h3C, lat, d);
    xfer(1'b0, 1'b0, 32'h10, 8'h00, lat, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL wrrd_u0 got=%h want=3c", d); end
    xfer(1'b1, 1'b1, 32'h410, 8'h5A, lat, d);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ws0_write_lat got=%0d want=2", lat); end
    xfer(1'b1, 1'b0, 32'h410, 8'h00, lat, d);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ws0_read_lat got=%0d want=2", lat); end
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL wrrd_u1 got=%h want=5a", d); end
  endtask

  task automatic test_decode();
    int lat; logic [7:0] d; int bad;
    bad = 0;
    addr = 32'h3FF; rd_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fc1 !== 1'b0 || data1 !== 8'hFF) bad++;
    end
    rd_s = 1'b0; tick();
    checks++; if (bad != 0) begin failures++; $display("FAIL decode_below got=%0d responses want=0", bad); end
    bad = 0;
    addr = 32'h800; rd_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fc0 !== 1'b0 || fc1 !== 1'b0 || data1 !== 8'hFF) bad++;
    end
    rd_s = 1'b0; tick();
    checks++; if (bad != 0) begin failures++; $display("FAIL decode_above got=%0d responses want=0", bad); end
    xfer(1'b1, 1'b1, 32'h400, 8'hC3, lat, d);
    xfer(1'b1, 1'b1, 32'h401, 8'h3D, lat, d);
    xfer(1'b1, 1'b0, 32'h400, 8'h00, lat, d);
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL decode_base got=%h want=c3", d); end
    xfer(1'b1, 1'b0, 32'h401, 8'h00, lat, d);
    checks++; if (d !== 8'h3D) begin failures++; $display("FAIL decode_base1 got=%h want=3d", d); end
  endtask

  task automatic test_capture();
    int lat; logic [7:0] d; bit seen;
    xfer(1'b0, 1'b1, 32'h31, 8'h00, lat, d);
    addr = 32'h30; wr_s = 1'b1; tb_den = 1'b1; tb_dat = 8'h77;
    tick();
    addr = 32'h31; tb_dat = 8'h88;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fc0 === 1'b1) seen = 1'b1;
    end
    wr_s = 1'b0; tb_den = 1'b0; tick();
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL capture_fc got=%b want=1", seen); end
    xfer(1'b0, 1'b0, 32'h30, 8'h00, lat, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL capture_addr got=%h want=77", d); end
    xfer(1'b0, 1'b0, 32'h31, 8'h00, lat, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL capture_other got=%h want=00", d); end
  endtask

  task automatic test_abort_error();
    int lat; logic [7:0] d; int bad;
    addr = 32'h5; rd_s = 1'b1;
    tick(); tick();
    rd_s = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (fc0 === 1'b1) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_rd_fc got=%0d want=0", bad); end
    xfer(1'b0, 1'b0, 32'h5, 8'h00, lat, d);
    checks++; if (lat !== 4 || d !== 8'hA7) begin failures++; $display("FAIL after_abort got=%0d/%h want=4/a7", lat, d); end
    xfer(1'b0, 1'b1, 32'h20, 8'h12, lat, d);
    addr = 32'h20; wr_s = 1'b1; tb_den = 1'b1; tb_dat = 8'h99;
    tick(); tick();
    wr_s = 1'b0; tb_den = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    xfer(1'b0, 1'b0, 32'h20, 8'h00, lat, d);
    checks++; if (d !== 8'h12) begin failures++; $display("FAIL abort_wr_data got=%h want=12", d); end
    addr = 32'h5; rd_s = 1'b1; wr_s = 1'b1; tb_den = 1'b1; tb_dat = 8'h00;
    bad = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (fc0 === 1'b1) bad++; end
    rd_s = 1'b0; wr_s = 1'b0; tb_den = 1'b0; tick();
    checks++; if (bad != 0) begin failures++; $display("FAIL both_strobes_fc got=%0d want=0", bad); end
    xfer(1'b0, 1'b0, 32'h5, 8'h00, lat, d);
    checks++; if (d !== 8'hA7) begin failures++; $display("FAIL both_strobes_data got=%h want=a7", d); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] d; bit seen;
    xfer(1'b0, 1'b1, 32'h2, 8'h11, lat, d);
    addr = 32'h2; wr_s = 1'b1; tb_den = 1'b1; tb_dat = 8'hFF;
    tick(); tick();
    rst = 1'b1; #2;
    checks++; if (fc0 !== 1'b0) begin failures++; $display("FAIL rst_busy_fc got=%b want=0", fc0); end
    wr_s = 1'b0; tb_den = 1'b0; rst = 1'b0;
    tick();
    xfer(1'b0, 1'b0, 32'h2, 8'h00, lat, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL rst_write_lost got=%h want=11", d); end
    addr = 32'h5; rd_s = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (fc0 === 1'b1) seen = 1'b1; end
    checks++; if (data0 !== 8'hA7) begin failures++; $display("FAIL ack_data got=%h want=a7", data0); end
    rst = 1'b1; #2;
    checks++; if (data0 !== 8'hFF || fc0 !== 1'b0) begin failures++; $display("FAIL rst_ack_release got=%h/%b want=ff/0", data0, fc0); end
    rd_s = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_write_protect();
    int lat; logic [7:0] d;
    xfer(1'b0, 1'b1, 32'h4, 8'h44, lat, d);
    xfer(1'b0, 1'b1, 32'h4, 8'h55, lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wp_handshake got=%0d want=4", lat); end
    xfer(1'b0, 1'b0, 32'h4, 8'h00, lat, d);
`ifdef MEM_WRITE_PROTECT_EN
    checks++; if (d === 8'h55) begin failures++; $display("FAIL wp_blocked got=%h want=not 55", d); end
`else
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL wp_off_write got=%h want=55", d); end
`endif
    xfer(1'b0, 1'b1, 32'h10, 8'h01, lat, d);
    xfer(1'b0, 1'b1, 32'h10, 8'h55, lat, d);
    xfer(1'b0, 1'b0, 32'h10, 8'h00, lat, d);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL wp_top_write got=%h want=55", d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] d;
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b1, 32'h500 + i, 8'hE0 + 8'(i), lat, d);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 32'h500 + i, 8'h00, lat, d);
      checks++;
      if (lat !== 2 || d !== 8'hE0 + 8'(i)) begin
        failures++; $display("FAIL b2b_%0d got=%0d/%h want=2/%h", i, lat, d, 8'hE0 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_readback();
    test_decode();
    test_capture();
    test_abort_error();
    test_reset_mid();
    test_write_protect();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
